// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: kicks the core via porst, waits for it to settle,
// confirms vbg through a debounced window-comparator flag, and re-kicks with a
// bounded retry budget before latching a sticky fault.
module bgr_startup_ctrl #(
  parameter int unsigned KICK_CYCLES   = 64,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned DEBOUNCE      = 16,
  parameter int unsigned TIMEOUT       = 1024,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       vbg_ok_async,
  input  logic       clr_fault,
  output logic       porst,
  output logic       bgr_ready,
  output logic       bgr_fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KICK   = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_READY  = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  // Counters start at 0 on state entry, so the last cycle of a phase is N-1.
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] KICK_LAST   = CNT_W'(KICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX   = CNT_W'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] tries_q, tries_d;
  logic [1:0]       retry_q, retry_d;
  logic             porst_q, ready_q, fault_q;
  logic             sync1_q, ok_s_q;
  logic             retry_req;

  // Two-flop synchronizer for the asynchronous comparator flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      ok_s_q  <= 1'b0;
    end else begin
      sync1_q <= vbg_ok_async;
      ok_s_q  <= sync1_q;
    end
  end

  // Next-state, counter and retry bookkeeping.
  // tries_q counts attempts at full width so the FAULT decision stays correct
  // when MAX_RETRY exceeds what the saturating 2-bit retry_cnt can show.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + ONE;
    deb_d     = deb_q;
    tries_d   = tries_q;
    retry_d   = retry_q;
    retry_req = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        deb_d = '0;
        if (en) begin
          state_d = S_KICK;
          tries_d = '0;
          retry_d = '0;
        end
      end
      S_KICK: begin
        if (cnt_q == KICK_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
          deb_d   = '0;
        end
      end
      S_CHECK: begin
        deb_d = ok_s_q ? deb_q + ONE : '0;
        // A good sample completing the debounce beats a simultaneous timeout.
        if (ok_s_q && (deb_q == DEB_LAST)) begin
          state_d = S_READY;
          cnt_d   = '0;
          deb_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          retry_req = 1'b1;
        end
      end
      S_READY: begin
        cnt_d = '0;
        deb_d = ok_s_q ? '0 : deb_q + ONE;
        if (!ok_s_q && (deb_q == DEB_LAST)) retry_req = 1'b1;
      end
      S_FAULT: begin
        cnt_d = '0;
        deb_d = '0;
        if (clr_fault) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        deb_d   = '0;
      end
    endcase

    if (retry_req) begin
      cnt_d = '0;
      deb_d = '0;
      if (tries_q < RETRY_MAX) begin
        state_d = S_KICK;
        tries_d = tries_q + ONE;
        if (retry_q != 2'd3) retry_d = retry_q + 2'd1;
      end else begin
        state_d = S_FAULT;
      end
    end

    // Dropping enable aborts any non-fault phase, including a kick in progress.
    if (!en && (state_q != S_FAULT)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      deb_d   = '0;
    end
  end

  // FSM state and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      deb_q   <= '0;
      tries_q <= '0;
      retry_q <= '0;
      porst_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      tries_q <= tries_d;
      retry_q <= retry_d;
      porst_q <= (state_d == S_KICK);
      ready_q <= (state_d == S_READY);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign porst     = porst_q;
  assign bgr_ready = ready_q;
  assign bgr_fault = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
